// File: rtl/simprisc_arith_core.sv
// RV32I arithmetic responder: IDLE -> DECODE -> EXEC -> RESP, one instruction in flight.
// Optional MUL support is built when SIMPRISC_MUL_EN is defined.
module simprisc_arith_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [4:0]       res_rd,
  output logic [XLEN-1:0]  res_data,
  output logic             res_illegal,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  alu_op_t           alu_op_q, alu_op_d;
  logic              illegal_q, illegal_d;
  logic [4:0]        res_rd_q, res_rd_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic              res_illegal_q, res_illegal_d;
  logic [CNT_W-1:0]  retire_q, retire_d, ill_cnt_q, ill_cnt_d;
  logic [XLEN-1:0]   regs_q [32];

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [4:0]        rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]   rs1_val, rs2_val, imm_i, imm_u;
  logic              dec_legal;
  alu_op_t           dec_op;
  logic [XLEN-1:0]   dec_a, dec_b, alu_res;
  logic [4:0]        shamt;
  logic              wr_en;

  assign opcode  = instr_q[6:0];
  assign rd_idx  = instr_q[11:7];
  assign funct3  = instr_q[14:12];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];
  assign funct7  = instr_q[31:25];
  assign imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_u   = {instr_q[31:12], 12'b0};
  // x0 is never written, but the guard keeps reads independent of that invariant.
  assign rs1_val = (rs1_idx == 5'd0) ? '0 : regs_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : regs_q[rs2_idx];

  assign instr_ready = (state_q == S_IDLE) && rst_n;
  assign res_valid   = (state_q == S_RESP);
  assign res_rd      = res_rd_q;
  assign res_data    = res_data_q;
  assign res_illegal = res_illegal_q;
  assign retire_cnt  = retire_q;
  assign illegal_cnt = ill_cnt_q;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_a     = rs1_val;
    dec_b     = rs2_val;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        if (opcode == OPC_OP_IMM) dec_b = imm_i;
        case (funct3)
          3'b000:  dec_op = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_op = ALU_SLL;
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b101:  dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
        if (opcode == OPC_OP) begin
          if (funct7 == 7'b0000000)
            dec_legal = 1'b1;
          else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
            dec_legal = 1'b1;
`ifdef SIMPRISC_MUL_EN
          else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_op    = ALU_MUL;
          end
`endif
        end else begin
          // Only the shift-immediates constrain the upper immediate bits.
          case (funct3)
            3'b001:  dec_legal = (funct7 == 7'b0000000);
            3'b101:  dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            default: dec_legal = 1'b1;
          endcase
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_a     = '0;
        dec_b     = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign shamt = op_b_q[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_q)
      ALU_ADD:  alu_res = op_a_q + op_b_q;
      ALU_SUB:  alu_res = op_a_q - op_b_q;
      ALU_SLL:  alu_res = op_a_q << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_q) < $signed(op_b_q))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a_q < op_b_q)};
      ALU_XOR:  alu_res = op_a_q ^ op_b_q;
      ALU_SRL:  alu_res = op_a_q >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a_q) >>> shamt);
      ALU_OR:   alu_res = op_a_q | op_b_q;
      ALU_AND:  alu_res = op_a_q & op_b_q;
`ifdef SIMPRISC_MUL_EN
      ALU_MUL:  alu_res = op_a_q * op_b_q;
`endif
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    alu_op_d      = alu_op_q;
    illegal_d     = illegal_q;
    res_rd_d      = res_rd_q;
    res_data_d    = res_data_q;
    res_illegal_d = res_illegal_q;
    retire_d      = retire_q;
    ill_cnt_d     = ill_cnt_q;
    wr_en         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_a_d    = dec_a;
        op_b_d    = dec_b;
        alu_op_d  = dec_op;
        illegal_d = !dec_legal;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        res_rd_d      = rd_idx;
        res_illegal_d = illegal_q;
        res_data_d    = illegal_q ? '0 : alu_res;
        wr_en         = !illegal_q && (rd_idx != 5'd0);
        state_d       = S_RESP;
      end
      default: begin
        if (res_ready) begin
          if (res_illegal_q) ill_cnt_d = ill_cnt_q + 1'b1;
          else               retire_d  = retire_q + 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      alu_op_q      <= ALU_ADD;
      illegal_q     <= 1'b0;
      res_rd_q      <= '0;
      res_data_q    <= '0;
      res_illegal_q <= 1'b0;
      retire_q      <= '0;
      ill_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      alu_op_q      <= alu_op_d;
      illegal_q     <= illegal_d;
      res_rd_q      <= res_rd_d;
      res_data_q    <= res_data_d;
      res_illegal_q <= res_illegal_d;
      retire_q      <= retire_d;
      ill_cnt_q     <= ill_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd_idx] <= alu_res;
    end
  end

endmodule

// File: tb/tb_simprisc_arith_core.sv
// Directed-vector bench for simprisc_arith_core: table of instructions with
// hand-computed results, plus back-pressure and mid-operation reset sequences.
module tb_simprisc_arith_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'h0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [4:0]  res_rd;
  logic [31:0] res_data;
  logic        res_illegal;
  logic [15:0] retire_cnt;
  logic [15:0] illegal_cnt;

  simprisc_arith_core #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_rd(res_rd), .res_data(res_data), .res_illegal(res_illegal),
    .retire_cnt(retire_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          txn = 0;
  logic [15:0] exp_retire = 16'd0;
  logic [15:0] exp_ill = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 20);
  endtask

  // Offer the instruction from a negedge and return with the pipeline at the handshake edge +1.
  task automatic offer(input logic [31:0] ins);
    int k;
    instr       = ins;
    instr_valid = 1'b1;
    k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    offer(v.ins);
    wait_result(lat);
    $display("txn %0d instr=%08h rd=%0d data=%08h illegal=%0b lat=%0d",
             txn, v.ins, res_rd, res_data, res_illegal, lat);
    check("latency", 32'(lat), 32'd3);
    check("res_rd", 32'(res_rd), 32'(v.rd));
    check("res_data", res_data, v.data);
    check("res_illegal", 32'(res_illegal), 32'(v.ill));
    if (v.ill) exp_ill++;
    else       exp_retire++;
    txn++;
  endtask

  initial begin
    int lat;
    vecs.push_back('{32'h00500093, 5'd1,  32'h00000005, 1'b0}); // ADDI x1,x0,5
    vecs.push_back('{32'h00108133, 5'd2,  32'h0000000A, 1'b0}); // ADD x2,x1,x1
    vecs.push_back('{32'h401001B3, 5'd3,  32'hFFFFFFFB, 1'b0}); // SUB x3,x0,x1
    vecs.push_back('{32'h4011D213, 5'd4,  32'hFFFFFFFD, 1'b0}); // SRAI x4,x3,1
    vecs.push_back('{32'h00700013, 5'd0,  32'h00000007, 1'b0}); // ADDI x0,x0,7
    vecs.push_back('{32'h000002B3, 5'd5,  32'h00000000, 1'b0}); // ADD x5,x0,x0
    vecs.push_back('{32'h0000007F, 5'd0,  32'h00000000, 1'b1}); // unknown opcode
`ifdef SIMPRISC_MUL_EN
    vecs.push_back('{32'h021082B3, 5'd5,  32'h00000019, 1'b0}); // MUL x5,x1,x1
`else
    vecs.push_back('{32'h021082B3, 5'd5,  32'h00000000, 1'b1}); // MUL absent
`endif
    vecs.push_back('{32'h0011A333, 5'd6,  32'h00000001, 1'b0}); // SLT x6,x3,x1
    vecs.push_back('{32'h0011B3B3, 5'd7,  32'h00000000, 1'b0}); // SLTU x7,x3,x1
    vecs.push_back('{32'hFFF0B413, 5'd8,  32'h00000001, 1'b0}); // SLTIU x8,x1,-1
    vecs.push_back('{32'h123454B7, 5'd9,  32'h12345000, 1'b0}); // LUI x9,0x12345
    vecs.push_back('{32'hFFF4C513, 5'd10, 32'hEDCBAFFF, 1'b0}); // XORI x10,x9,-1
    vecs.push_back('{32'h00409593, 5'd11, 32'h00000050, 1'b0}); // SLLI x11,x1,4
    vecs.push_back('{32'h40409593, 5'd11, 32'h00000000, 1'b1}); // SLLI bad imm[11:5]
    vecs.push_back('{32'h00058633, 5'd12, 32'h00000050, 1'b0}); // ADD x12,x11,x0
    vecs.push_back('{32'h0011D6B3, 5'd13, 32'h07FFFFFF, 1'b0}); // SRL x13,x3,x1
    vecs.push_back('{32'h4011D733, 5'd14, 32'hFFFFFFFF, 1'b0}); // SRA x14,x3,x1
    vecs.push_back('{32'h0020E7B3, 5'd15, 32'h0000000F, 1'b0}); // OR x15,x1,x2
    vecs.push_back('{32'h4020C7B3, 5'd15, 32'h00000000, 1'b1}); // XOR with funct7=0100000
    vecs.push_back('{32'h00518813, 5'd16, 32'h00000000, 1'b0}); // ADDI x16,x3,5 wraps
    vecs.push_back('{32'h0F01F893, 5'd17, 32'h000000F0, 1'b0}); // ANDI x17,x3,0xF0
    vecs.push_back('{32'h6011D213, 5'd4,  32'h00000000, 1'b1}); // SRAI bad imm[11:5]

    // Reset state
    #2;
    check("rst_instr_ready", 32'(instr_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_rd", 32'(res_rd), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_illegal", 32'(res_illegal), 32'd0);
    check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);
    @(negedge clk);
    check("retire_cnt", 32'(retire_cnt), 32'(exp_retire));
    check("illegal_cnt", 32'(illegal_cnt), 32'(exp_ill));

    // Back-pressure: result held 10 cycles while another instruction is offered
    res_ready = 1'b0;
    offer(32'h12300913); // ADDI x18,x0,0x123
    wait_result(lat);
    check("stall_latency", 32'(lat), 32'd3);
    instr       = 32'h00190993; // ADDI x19,x18,1
    instr_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_res_rd", 32'(res_rd), 32'd18);
      check("stall_res_data", res_data, 32'h00000123);
      check("stall_instr_ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
    end
    $display("txn %0d instr=12300913 rd=%0d data=%08h illegal=%0b held 10 cycles",
             txn, res_rd, res_data, res_illegal);
    txn++;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_stall_valid", 32'(res_valid), 32'd0);
    check("after_stall_ready", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    wait_result(lat);
    $display("txn %0d instr=00190993 rd=%0d data=%08h illegal=%0b lat=%0d",
             txn, res_rd, res_data, res_illegal, lat);
    txn++;
    check("follow_latency", 32'(lat), 32'd3);
    check("follow_rd", 32'(res_rd), 32'd19);
    check("follow_data", res_data, 32'h00000124);
    exp_retire += 16'd2;
    @(negedge clk);
    check("retire_after_stall", 32'(retire_cnt), 32'(exp_retire));

    // Reset during EXEC: the write and the result are both dropped
    offer(32'h00900A13); // ADDI x20,x0,9
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_ready", 32'(instr_ready), 32'd0);
    check("midrst_retire", 32'(retire_cnt), 32'd0);
    check("midrst_illegal", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(res_valid), 32'd0);
    end
    $display("txn %0d instr=00900A13 aborted by reset", txn);
    txn++;
    exp_retire = 16'd0;
    exp_ill    = 16'd0;
    run_vec('{32'h001A0AB3, 5'd21, 32'h00000000, 1'b0}); // ADD x21,x20,x1 after reset
    @(negedge clk);
    check("final_retire", 32'(retire_cnt), 32'(exp_retire));
    check("final_illegal", 32'(illegal_cnt), 32'(exp_ill));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
